// File: rtl/pot_scheduler_if.sv
// Pot scheduler bus: CIA1 pot select, control-port pot inputs, SID pot outputs.
// The master modport drives select and pot inputs; the slave (scheduler) publishes.
interface pot_scheduler_if;
    logic [1:0] sel;
    logic [7:0] p1_potx;
    logic [7:0] p1_poty;
    logic [7:0] p2_potx;
    logic [7:0] p2_poty;
    logic [7:0] pot_x;
    logic [7:0] pot_y;
    logic       sample_strobe;
    logic       phase;

    modport master (
        output sel, p1_potx, p1_poty, p2_potx, p2_poty,
        input  pot_x, pot_y, sample_strobe, phase
    );

    modport slave (
        input  sel, p1_potx, p1_poty, p2_potx, p2_poty,
        output pot_x, pot_y, sample_strobe, phase
    );
endinterface

// File: rtl/pot_scheduler.sv
// SID pot sampling scheduler: 256-tick DISCHARGE then 256-tick COUNT, values
// captured at DISCHARGE exit and published at COUNT exit.
// Optional feature macro POT_SEL_GUARD_EN: skip a publish when sel changed
// during COUNT.
module pot_scheduler #(
    parameter logic [7:0] RESET_POT = 8'hFF
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            ce_1m,
    pot_scheduler_if.slave  bus
);

    typedef enum logic {StDischarge = 1'b0, StCount = 1'b1} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] shadow_x_q, shadow_x_d;
    logic [7:0] shadow_y_q, shadow_y_d;
    logic [7:0] pot_x_q, pot_x_d;
    logic [7:0] pot_y_q, pot_y_d;
    logic       strobe_q, strobe_d;
    logic [7:0] cap_x, cap_y;
`ifdef POT_SEL_GUARD_EN
    logic       guard_q, guard_d;
    logic [1:0] sel_cap_q, sel_cap_d;
    logic       sel_change;
`endif

    // Select the pot pair to capture; both ports wired-AND like the real lines.
    always_comb begin
        cap_x = 8'hFF;
        cap_y = 8'hFF;
        unique case (bus.sel)
            2'b01: begin cap_x = bus.p1_potx;                cap_y = bus.p1_poty;                end
            2'b10: begin cap_x = bus.p2_potx;                cap_y = bus.p2_poty;                end
            2'b11: begin cap_x = bus.p1_potx & bus.p2_potx;  cap_y = bus.p1_poty & bus.p2_poty;  end
            2'b00: begin cap_x = 8'hFF;                      cap_y = 8'hFF;                      end
        endcase
    end

    // Next-state: phase sequencing, capture and publish on ce_1m ticks only.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        pot_x_d    = pot_x_q;
        pot_y_d    = pot_y_q;
        strobe_d   = 1'b0;
`ifdef POT_SEL_GUARD_EN
        guard_d    = guard_q;
        sel_cap_d  = sel_cap_q;
        sel_change = (bus.sel != sel_cap_q);
`endif
        if (ce_1m) begin
            unique case (state_q)
                StDischarge: begin
                    if (cnt_q == 8'hFF) begin
                        state_d    = StCount;
                        cnt_d      = 8'd0;
                        shadow_x_d = cap_x;
                        shadow_y_d = cap_y;
`ifdef POT_SEL_GUARD_EN
                        guard_d    = 1'b0;
                        sel_cap_d  = bus.sel;
`endif
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StCount: begin
                    if (cnt_q == 8'hFF) begin
                        state_d = StDischarge;
                        cnt_d   = 8'd0;
`ifdef POT_SEL_GUARD_EN
                        guard_d = 1'b0;
                        if (!(guard_q || sel_change)) begin
                            pot_x_d  = shadow_x_q;
                            pot_y_d  = shadow_y_q;
                            strobe_d = 1'b1;
                        end
`else
                        pot_x_d  = shadow_x_q;
                        pot_y_d  = shadow_y_q;
                        strobe_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 8'd1;
`ifdef POT_SEL_GUARD_EN
                        if (sel_change) guard_d = 1'b1;
`endif
                    end
                end
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StDischarge;
            cnt_q      <= 8'd0;
            shadow_x_q <= RESET_POT;
            shadow_y_q <= RESET_POT;
            pot_x_q    <= RESET_POT;
            pot_y_q    <= RESET_POT;
            strobe_q   <= 1'b0;
`ifdef POT_SEL_GUARD_EN
            guard_q    <= 1'b0;
            sel_cap_q  <= 2'b00;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_x_q <= shadow_x_d;
            shadow_y_q <= shadow_y_d;
            pot_x_q    <= pot_x_d;
            pot_y_q    <= pot_y_d;
            strobe_q   <= strobe_d;
`ifdef POT_SEL_GUARD_EN
            guard_q    <= guard_d;
            sel_cap_q  <= sel_cap_d;
`endif
        end
    end

    assign bus.pot_x         = pot_x_q;
    assign bus.pot_y         = pot_y_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.phase         = state_q;

endmodule
